// File: rtl/i2s_dac_tx_pkg.sv
// Shared I2S timing definitions: divider bit positions, slot geometry and slot classification.
// The upstream I2S receiver imports the same package so both ends agree on frame layout.
package i2s_dac_tx_pkg;

  localparam int CNT_W    = 10;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 3;
  localparam int LRCK_BIT = 9;
  localparam int SLOT_LSB = 4;
  localparam int SLOTS    = 32;
  localparam int SLOT_W   = $clog2(SLOTS);

  localparam logic [CNT_W-1:0] CNT_LAST  = '1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_LAST >> 1;

  typedef enum logic [1:0] {
    SLOT_DELAY,
    SLOT_DATA,
    SLOT_PAD
  } slot_kind_e;

  // Slot 0 is the I2S one-bit delay, slots 1..dw carry data MSB first, the rest are padding.
  function automatic slot_kind_e slot_kind(input logic [SLOT_W-1:0] slot, input int dw);
    slot_kind_e kind;
    if (slot == '0)
      kind = SLOT_DELAY;
    else if (int'(slot) <= dw)
      kind = SLOT_DATA;
    else
      kind = SLOT_PAD;
    return kind;
  endfunction

endpackage

// File: rtl/i2s_dac_tx_clkgen.sv
// Free-running frame counter producing MCLK/SCLK/LRCK as plain register bits,
// plus the load and bit-tick strobes that pace the serializer in the top level.
module i2s_dac_tx_clkgen
  import i2s_dac_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic              frame_strobe,
  output logic              load_left,
  output logic              load_right,
  output logic              bit_tick,
  output logic [SLOT_W-1:0] slot_next
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Registered one cycle early so the strobe is high exactly while the counter sits at its last value.
  always_ff @(posedge clk) begin
    if (!rst)
      frame_strobe <= 1'b0;
    else
      frame_strobe <= (cnt == CNT_LAST - 1'b1);
  end

  assign mclk = cnt[MCLK_BIT];
  assign sclk = cnt[SCLK_BIT];
  assign lrck = cnt[LRCK_BIT];

  // Strobes describe what happens at the coming edge: frame/half-frame start and SCLK falling edge.
  assign load_left  = (cnt == CNT_LAST);
  assign load_right = (cnt == HALF_LAST);
  assign bit_tick   = &cnt[SLOT_LSB-1:0];
  assign slot_next  = cnt[LRCK_BIT-1:SLOT_LSB] + 1'b1;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the CS4344 DAC: buffers one mono sample from the FIR and plays it
// on both channels of the next frame, with sticky underrun/overrun reporting.
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          mclk,
  output logic          sclk,
  output logic          lrck,
  output logic          sdout,
  output logic          frame_strobe,
  output logic          underrun,
  output logic          overrun
);

  logic              load_left;
  logic              load_right;
  logic              bit_tick;
  logic [SLOT_W-1:0] slot_next;

  logic [DW-1:0] hold;
  logic          hold_full;
  logic [DW-1:0] frame;
  logic [DW-1:0] frame_next;
  logic [DW-1:0] sh;
  slot_kind_e    kind;

  i2s_dac_tx_clkgen u_clkgen (
    .clk          (clk),
    .rst          (rst),
    .mclk         (mclk),
    .sclk         (sclk),
    .lrck         (lrck),
    .frame_strobe (frame_strobe),
    .load_left    (load_left),
    .load_right   (load_right),
    .bit_tick     (bit_tick),
    .slot_next    (slot_next)
  );

  // A sample arriving in the load cycle bypasses the hold register; with nothing new the old frame repeats.
  always_comb begin
    frame_next = frame;
    if (din_valid)
      frame_next = din;
    else if (hold_full)
      frame_next = hold;
  end

  always_comb begin
    kind = slot_kind(slot_next, DW);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (din_valid)
        hold <= din;
      if (load_left)
        hold_full <= 1'b0;
      else if (din_valid)
        hold_full <= 1'b1;
      if (din_valid && hold_full && !load_left)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame    <= '0;
      underrun <= 1'b0;
    end else if (load_left) begin
      frame <= frame_next;
      if (!hold_full && !din_valid)
        underrun <= 1'b1;
    end
  end

  // Shift on SCLK falling edges inside the data slots; both channels reload from the same sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh    <= '0;
      sdout <= 1'b0;
    end else begin
      if (load_left)
        sh <= frame_next;
      else if (load_right)
        sh <= frame;
      else if (bit_tick && kind == SLOT_DATA)
        sh <= {sh[DW-2:0], 1'b0};
      if (bit_tick) begin
        if (kind == SLOT_DATA)
          sdout <= sh[DW-1];
        else
          sdout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: table of single samples and their expected 32-slot words,
// plus hand-written sequences for load-cycle bypass, overrun and mid-frame reset.
module tb_i2s_dac_tx;

  logic        clk;
  logic        rst;
  logic [23:0] din;
  logic        din_valid;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdout;
  logic        frame_strobe;
  logic        underrun;
  logic        overrun;

  logic [9:0]  ref_cnt;
  int          checks;
  int          errors;

  typedef struct {
    logic [23:0] sample;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [5];

  i2s_dac_tx #(.DW(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .mclk         (mclk),
    .sclk         (sclk),
    .lrck         (lrck),
    .sdout        (sdout),
    .frame_strobe (frame_strobe),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame position, reset the same way the design's counter is.
  always @(posedge clk) begin
    if (!rst)
      ref_cnt <= '0;
    else
      ref_cnt <= ref_cnt + 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic wait_cnt(input int target);
    int guard;
    guard = 0;
    while (int'(ref_cnt) != target && guard < 2100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2100)
      checkOutput("wait_cnt_timeout", 32'(ref_cnt), 32'(target));
  endtask

  task automatic applyStimulus(input int at, input logic [23:0] value);
    wait_cnt(at);
    din       = value;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic capture_word(input int base, output logic [31:0] w);
    w = '0;
    for (int s = 0; s < 32; s++) begin
      wait_cnt(base + 16 * s + 8);
      w[31-s] = sdout;
    end
  endtask

  // Runs one full frame comparing the divided clocks, frame_strobe and sdout against the reference counter.
  task automatic check_idle_frame(input string tag);
    int bad_clk;
    int bad_fs;
    int bad_sd;
    bad_clk = 0;
    bad_fs  = 0;
    bad_sd  = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (mclk !== ref_cnt[1] || sclk !== ref_cnt[3] || lrck !== ref_cnt[9])
        bad_clk++;
      if (frame_strobe !== (ref_cnt == 10'd1023))
        bad_fs++;
      if (sdout !== 1'b0)
        bad_sd++;
      if (ref_cnt == 10'd1023)
        checkOutput({tag, "_flags_before_load"}, {30'b0, underrun, overrun}, 32'h0);
    end
    checkOutput({tag, "_clock_dividers"}, 32'(bad_clk), 32'h0);
    checkOutput({tag, "_frame_strobe"}, 32'(bad_fs), 32'h0);
    checkOutput({tag, "_sdout_idle"}, 32'(bad_sd), 32'h0);
    checkOutput({tag, "_underrun_first_load"}, {31'b0, underrun}, 32'h1);
  endtask

  initial begin
    logic [31:0] w;
    checks    = 0;
    errors    = 0;
    din       = '0;
    din_valid = 1'b0;
    rst       = 1'b0;

    vecs[0] = '{24'h400000, 32'h2000_0000};
    vecs[1] = '{24'h800001, 32'h4000_0080};
    vecs[2] = '{24'h123456, 32'h091A_2B00};
    vecs[3] = '{24'hA5A5A5, 32'h52D2_D280};
    vecs[4] = '{24'h000001, 32'h0000_0080};

    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {25'b0, mclk, sclk, lrck, sdout, frame_strobe, underrun, overrun}, 32'h0);
    rst = 1'b1;

    check_idle_frame("startup");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(100, vecs[i].sample);
      capture_word(0, w);
      checkOutput($sformatf("left_word_%0d", i), w, vecs[i].word);
      capture_word(512, w);
      checkOutput($sformatf("right_word_%0d", i), w, vecs[i].word);
    end
    checkOutput("table_flags", {30'b0, underrun, overrun}, 32'h2);

    capture_word(0, w);
    checkOutput("underrun_repeats_frame", w, 32'h0000_0080);

    applyStimulus(1023, 24'hFFFFFF);
    capture_word(0, w);
    checkOutput("load_cycle_left", w, 32'h7FFF_FF80);
    capture_word(512, w);
    checkOutput("load_cycle_right", w, 32'h7FFF_FF80);
    checkOutput("load_cycle_no_overrun", {31'b0, overrun}, 32'h0);

    applyStimulus(500, 24'h0F0F0F);
    applyStimulus(1023, 24'hC00003);
    capture_word(0, w);
    checkOutput("bypass_over_hold", w, 32'h6000_0180);
    checkOutput("bypass_no_overrun", {31'b0, overrun}, 32'h0);

    applyStimulus(200, 24'h111111);
    checkOutput("single_no_overrun", {31'b0, overrun}, 32'h0);
    applyStimulus(300, 24'h222222);
    checkOutput("overrun_set", {31'b0, overrun}, 32'h1);
    capture_word(0, w);
    checkOutput("newest_sample_wins", w, 32'h1111_1100);

    wait_cnt(600);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midframe_reset_outputs", {25'b0, mclk, sclk, lrck, sdout, frame_strobe, underrun, overrun}, 32'h0);
    rst = 1'b1;
    check_idle_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
